// File: rtl/icache_fetch_ctrl_pkg.sv
// Shared state encodings, counter limit and instruction widening for the
// instruction-cache fetch controller.
package icache_fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH_IDLE  = 3'd0,
    FETCH_CHECK = 3'd1,
    FETCH_MEM   = 3'd2,
    FETCH_FILL  = 3'd3,
    FETCH_DRAIN = 3'd4
  } fetch_state_t;

  localparam logic [31:0] CNT_SAT = 32'hFFFF_FFFF;

  // 32-bit encodings pass through; compressed ones keep only the low halfword
  function automatic logic [31:0] expand_inst(input logic [31:0] word);
    return (word[1:0] == 2'b11) ? word : {16'b0, word[15:0]};
  endfunction

endpackage

// File: rtl/icache_fetch_ctrl_sat_counter.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module icache_fetch_ctrl_sat_counter
  import icache_fetch_ctrl_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        i_en,
  input  logic        i_inc,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_count <= '0;
    end else if (i_en && i_inc && (r_count != CNT_SAT)) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/icache_fetch_ctrl.sv
// Instruction-cache fetch sequencer: probe, single-word miss read, fill and
// deliver, with flush handling that lets an in-flight memory read drain.
module icache_fetch_ctrl
  import icache_fetch_ctrl_pkg::*;
(
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         rdy_in,
  input  logic         rob_clear_up,
  input  logic         fetch_req,
  input  logic [31:0]  fetch_pc,
  output logic         fetch_valid,
  output logic [31:0]  fetch_inst,
  output logic         fetch_is_i,
  output logic [31:0]  fetch_pc_out,
  output logic [31:0]  ic_addr,
  output logic         ic_wr,
  output logic [31:0]  ic_wdata,
  input  logic         ic_hit,
  input  logic [31:0]  ic_inst,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic [31:0]  mem_data,
  input  logic         mem_done,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt,
  output fetch_state_t o_dbg_state
);

  // Handshakes: fetch_req is a level held until the one-cycle fetch_valid
  // pulse; mem_req is a level held until the one-cycle mem_done pulse. A
  // request seen while fetch_valid is high is not accepted that cycle.

  fetch_state_t r_state, w_next;

  logic        r_hit_valid;
  logic [31:0] r_cur_pc;
  logic [31:0] r_fetch_inst;
  logic [31:0] r_fetch_pc_out;
  logic [31:0] r_fill_word;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;

  logic w_flush;
  logic w_accept;
  logic w_hit_fire;
  logic w_miss_fire;
  logic w_take_data;
  logic w_mem_clear;
  logic w_fill_fire;
  logic w_unused;

  assign w_flush  = rdy_in && rob_clear_up;
  assign w_unused = fetch_pc[0];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= FETCH_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_hit_fire  = 1'b0;
    w_miss_fire = 1'b0;
    w_take_data = 1'b0;
    w_mem_clear = 1'b0;
    w_fill_fire = 1'b0;
    if (rdy_in) begin
      case (r_state)
        FETCH_IDLE: begin
          if (!rob_clear_up && fetch_req && !r_hit_valid) begin
            w_accept = 1'b1;
            w_next   = FETCH_CHECK;
          end
        end
        FETCH_CHECK: begin
          if (rob_clear_up) begin
            w_next = FETCH_IDLE;
          end else if (ic_hit) begin
            w_hit_fire = 1'b1;
            w_next     = FETCH_IDLE;
          end else begin
            w_miss_fire = 1'b1;
            w_next      = FETCH_MEM;
          end
        end
        FETCH_MEM: begin
          if (mem_done) begin
            w_mem_clear = 1'b1;
            if (rob_clear_up) begin
              w_next = FETCH_IDLE;
            end else begin
              w_take_data = 1'b1;
              w_next      = FETCH_FILL;
            end
          end else if (rob_clear_up) begin
            w_next = FETCH_DRAIN;
          end
        end
        FETCH_FILL: begin
          w_fill_fire = !rob_clear_up;
          w_next      = FETCH_IDLE;
        end
        FETCH_DRAIN: begin
          // The memory port cannot abort, so the read completes and is dropped
          if (mem_done) begin
            w_mem_clear = 1'b1;
            w_next      = FETCH_IDLE;
          end
        end
        default: w_next = FETCH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_hit_valid    <= 1'b0;
      r_cur_pc       <= '0;
      r_fetch_inst   <= '0;
      r_fetch_pc_out <= '0;
      r_fill_word    <= '0;
      r_mem_req      <= 1'b0;
      r_mem_addr     <= '0;
    end else if (rdy_in) begin
      r_hit_valid <= w_hit_fire;
      if (w_accept) begin
        r_cur_pc <= {fetch_pc[31:1], 1'b0};
      end
      if (w_hit_fire) begin
        r_fetch_inst   <= expand_inst(ic_inst);
        r_fetch_pc_out <= r_cur_pc;
      end
      if (w_miss_fire) begin
        r_mem_req  <= 1'b1;
        r_mem_addr <= r_cur_pc;
      end
      if (w_mem_clear) begin
        r_mem_req <= 1'b0;
      end
      // Fill data goes straight into the delivery registers so they are
      // already valid during the single FILL cycle
      if (w_take_data) begin
        r_fill_word    <= mem_data;
        r_fetch_inst   <= expand_inst(mem_data);
        r_fetch_pc_out <= r_cur_pc;
      end
    end
  end

  icache_fetch_ctrl_sat_counter u_hit_cnt (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .i_en     (rdy_in),
    .i_inc    (w_hit_fire),
    .o_count  (hit_cnt)
  );

  icache_fetch_ctrl_sat_counter u_miss_cnt (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .i_en     (rdy_in),
    .i_inc    (w_miss_fire),
    .o_count  (miss_cnt)
  );

  assign fetch_valid  = (r_hit_valid && !w_flush) || w_fill_fire;
  assign fetch_inst   = r_fetch_inst;
  assign fetch_is_i   = (r_fetch_inst[1:0] == 2'b11);
  assign fetch_pc_out = r_fetch_pc_out;
  assign ic_addr      = r_cur_pc;
  assign ic_wr        = w_fill_fire;
  assign ic_wdata     = r_fill_word;
  assign mem_req      = r_mem_req;
  assign mem_addr     = r_mem_addr;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Directed bench for icache_fetch_ctrl: miss/fill, hits, compressed widening,
// flush while a read is in flight, pause inside FILL and async reset mid-read.
module tb_icache_fetch_ctrl;

  localparam logic [31:0] S_IDLE  = 32'd0;
  localparam logic [31:0] S_CHECK = 32'd1;
  localparam logic [31:0] S_MEM   = 32'd2;
  localparam logic [31:0] S_FILL  = 32'd3;
  localparam logic [31:0] S_DRAIN = 32'd4;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        rob_clear_up = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic        fetch_is_i;
  logic [31:0] fetch_pc_out;
  logic [31:0] ic_addr;
  logic        ic_wr;
  logic [31:0] ic_wdata;
  logic        ic_hit = 1'b0;
  logic [31:0] ic_inst = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data = '0;
  logic        mem_done = 1'b0;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  icache_fetch_ctrl dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .rdy_in       (rdy_in),
    .rob_clear_up (rob_clear_up),
    .fetch_req    (fetch_req),
    .fetch_pc     (fetch_pc),
    .fetch_valid  (fetch_valid),
    .fetch_inst   (fetch_inst),
    .fetch_is_i   (fetch_is_i),
    .fetch_pc_out (fetch_pc_out),
    .ic_addr      (ic_addr),
    .ic_wr        (ic_wr),
    .ic_wdata     (ic_wdata),
    .ic_hit       (ic_hit),
    .ic_inst      (ic_inst),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_done     (mem_done),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt),
    .o_dbg_state  (dbg_state)
  );

  // clock/reset
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] st();
    return {29'b0, dbg_state};
  endfunction

  task automatic start_req(input logic [31:0] pc);
    fetch_req = 1'b1;
    fetch_pc  = pc;
  endtask

  initial begin
    // reset
    tick();
    tick();
    check("rst_state", st(), S_IDLE);
    check("rst_valid", 32'(fetch_valid), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_ic_addr", ic_addr, 32'd0);
    check("rst_inst", fetch_inst, 32'd0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    rst_n_in = 1'b1;
    tick();

    // cold miss at 0x1000, mem_done in the third MEM cycle
    start_req(32'h0000_1000);
    tick();
    check("cm_state_check", st(), S_CHECK);
    check("cm_ic_addr", ic_addr, 32'h0000_1000);
    tick();
    check("cm_state_mem", st(), S_MEM);
    check("cm_mem_req", 32'(mem_req), 32'd1);
    check("cm_mem_addr", mem_addr, 32'h0000_1000);
    check("cm_miss_cnt", miss_cnt, 32'd1);
    tick();
    check("cm_mem_hold", 32'(mem_req), 32'd1);
    tick();
    mem_done = 1'b1;
    mem_data = 32'h00A0_0093;
    tick();
    mem_done = 1'b0;
    mem_data = 32'hDEAD_BEEF;
    check("cm_state_fill", st(), S_FILL);
    check("cm_ic_wr", 32'(ic_wr), 32'd1);
    check("cm_ic_wdata", ic_wdata, 32'h00A0_0093);
    check("cm_fill_addr", ic_addr, 32'h0000_1000);
    check("cm_valid", 32'(fetch_valid), 32'd1);
    check("cm_inst", fetch_inst, 32'h00A0_0093);
    check("cm_is_i", 32'(fetch_is_i), 32'd1);
    check("cm_pc_out", fetch_pc_out, 32'h0000_1000);
    check("cm_mem_drop", 32'(mem_req), 32'd0);
    fetch_req = 1'b0;
    tick();
    check("cm_state_idle", st(), S_IDLE);
    check("cm_valid_off", 32'(fetch_valid), 32'd0);
    check("cm_wr_off", 32'(ic_wr), 32'd0);

    // hit at 0x1000, then a back-to-back request held through fetch_valid
    start_req(32'h0000_1000);
    ic_hit  = 1'b1;
    ic_inst = 32'h00A0_0093;
    tick();
    check("hit_n1_valid", 32'(fetch_valid), 32'd0);
    tick();
    check("hit_n2_valid", 32'(fetch_valid), 32'd1);
    check("hit_inst", fetch_inst, 32'h00A0_0093);
    check("hit_pc_out", fetch_pc_out, 32'h0000_1000);
    check("hit_cnt1", hit_cnt, 32'd1);
    check("hit_no_mem", 32'(mem_req), 32'd0);
    check("hit_miss_cnt", miss_cnt, 32'd1);
    fetch_pc = 32'h0000_1004;
    ic_inst  = 32'h00B0_0113;
    tick();
    check("b2b_ignored", st(), S_IDLE);
    check("b2b_valid_off", 32'(fetch_valid), 32'd0);
    tick();
    check("b2b_accept", st(), S_CHECK);
    check("b2b_ic_addr", ic_addr, 32'h0000_1004);
    tick();
    check("b2b_valid", 32'(fetch_valid), 32'd1);
    check("b2b_inst", fetch_inst, 32'h00B0_0113);
    check("b2b_pc_out", fetch_pc_out, 32'h0000_1004);
    check("b2b_hit_cnt", hit_cnt, 32'd2);
    fetch_req = 1'b0;
    ic_hit    = 1'b0;
    tick();

    // compressed miss at 0x2002, data on the first MEM cycle
    start_req(32'h0000_2002);
    tick();
    tick();
    check("cx_mem_addr", mem_addr, 32'h0000_2002);
    mem_done = 1'b1;
    mem_data = 32'h1234_4505;
    tick();
    mem_done = 1'b0;
    check("cx_valid", 32'(fetch_valid), 32'd1);
    check("cx_inst", fetch_inst, 32'h0000_4505);
    check("cx_is_i", 32'(fetch_is_i), 32'd0);
    check("cx_wdata", ic_wdata, 32'h1234_4505);
    check("cx_pc_out", fetch_pc_out, 32'h0000_2002);
    fetch_req = 1'b0;
    tick();

    // flush one cycle after mem_req rises, mem_done four cycles later
    start_req(32'h0000_3000);
    tick();
    tick();
    check("fl_mem_req", 32'(mem_req), 32'd1);
    tick();
    rob_clear_up = 1'b1;
    fetch_req    = 1'b0;
    tick();
    rob_clear_up = 1'b0;
    check("fl_state_drain", st(), S_DRAIN);
    check("fl_req_held1", 32'(mem_req), 32'd1);
    tick();
    check("fl_req_held2", 32'(mem_req), 32'd1);
    tick();
    tick();
    mem_done = 1'b1;
    mem_data = 32'h0000_0013;
    #1;
    check("fl_no_wr", 32'(ic_wr), 32'd0);
    check("fl_no_valid", 32'(fetch_valid), 32'd0);
    tick();
    mem_done = 1'b0;
    check("fl_state_idle", st(), S_IDLE);
    check("fl_req_drop", 32'(mem_req), 32'd0);
    check("fl_no_valid2", 32'(fetch_valid), 32'd0);
    check("fl_miss_cnt", miss_cnt, 32'd3);

    // pause for three cycles inside FILL
    start_req(32'h0000_4000);
    tick();
    tick();
    mem_done = 1'b1;
    mem_data = 32'h0010_0093;
    tick();
    mem_done = 1'b0;
    rdy_in   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rdy_state", st(), S_FILL);
      check("rdy_no_wr", 32'(ic_wr), 32'd0);
      check("rdy_no_valid", 32'(fetch_valid), 32'd0);
      tick();
    end
    rdy_in = 1'b1;
    #1;
    check("rdy_wr", 32'(ic_wr), 32'd1);
    check("rdy_valid", 32'(fetch_valid), 32'd1);
    check("rdy_inst", fetch_inst, 32'h0010_0093);
    check("rdy_miss_cnt", miss_cnt, 32'd4);
    fetch_req = 1'b0;
    tick();
    check("rdy_idle", st(), S_IDLE);
    check("rdy_single_wr", 32'(ic_wr), 32'd0);
    check("rdy_single_valid", 32'(fetch_valid), 32'd0);

    // asynchronous reset while the read is outstanding
    start_req(32'h0000_5000);
    tick();
    tick();
    check("ar_mem_req_pre", 32'(mem_req), 32'd1);
    #2;
    rst_n_in = 1'b0;
    #1;
    check("ar_mem_req", 32'(mem_req), 32'd0);
    check("ar_mem_addr", mem_addr, 32'd0);
    check("ar_valid", 32'(fetch_valid), 32'd0);
    check("ar_hit_cnt", hit_cnt, 32'd0);
    check("ar_miss_cnt", miss_cnt, 32'd0);
    check("ar_state", st(), S_IDLE);
    tick();
    rst_n_in = 1'b1;
    ic_hit   = 1'b1;
    ic_inst  = 32'h0020_0113;
    tick();
    check("ar_fresh_check", st(), S_CHECK);
    check("ar_ic_addr", ic_addr, 32'h0000_5000);
    tick();
    check("ar_hit_valid", 32'(fetch_valid), 32'd1);
    check("ar_hit_cnt1", hit_cnt, 32'd1);
    check("ar_miss_cnt0", miss_cnt, 32'd0);
    fetch_req = 1'b0;
    ic_hit    = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_fetch_ctrl.md
# icache_fetch_ctrl

Sequencing controller for the instruction cache on the RV32IC fetch path. It takes one fetch request at a time from the instruction-fetch stage and probes the cache. On a miss it runs a single 32-bit memory read, then writes the returned word into the cache and delivers the instruction to the fetch stage in the same cycle. It handles ROB flushes, including flushes that arrive while a memory read is in flight, and keeps hit/miss performance counters.

## Interface
Parameters:
- none; all address and data widths are fixed at 32.

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  pause; when low, all state and outputs hold
- rob_clear_up  in  1  flush; abandon the current fetch
- fetch_req  in  1  request level, held until fetch_valid
- fetch_pc  in  32  halfword-aligned fetch address; bit 0 is forced to 0
- fetch_valid  out  1  one-cycle pulse, instruction ready
- fetch_inst  out  32  instruction; compressed instructions are zero-extended in [31:16]
- fetch_is_i  out  1  1 when fetch_inst[1:0]==2'b11 (32-bit instruction)
- fetch_pc_out  out  32  PC of the delivered instruction
- ic_addr  out  32  cache lookup/write address
- ic_wr  out  1  cache write strobe
- ic_wdata  out  32  cache fill word
- ic_hit  in  1  cache hit (combinational from ic_addr)
- ic_inst  in  32  cache read data
- mem_req  out  1  memory read request, level held until mem_done
- mem_addr  out  32  memory read address
- mem_data  in  32  read data, valid when mem_done
- mem_done  in  1  one-cycle read completion
- hit_cnt  out  32  saturating hit counter
- miss_cnt  out  32  saturating miss counter

## Operation
- States: IDLE, CHECK, MEM, FILL, DRAIN.
- IDLE:
  - If fetch_req is high and fetch_valid is low, latch cur_pc = {fetch_pc[31:1],1'b0} and go to CHECK.
  - While fetch_valid is high, fetch_req is ignored.
- CHECK:
  - ic_addr = cur_pc.
  - On ic_hit: register fetch_inst = ic_inst, fetch_pc_out = cur_pc, fetch_valid = 1; increment hit_cnt; go to IDLE.
  - On miss: mem_req = 1, mem_addr = cur_pc; increment miss_cnt; go to MEM.
- MEM:
  - Hold mem_req and mem_addr.
  - On mem_done: latch mem_data into fill_word, drop mem_req, go to FILL.
- FILL (one cycle):
  - ic_wr = 1, ic_addr = cur_pc, ic_wdata = fill_word.
  - Register fetch_inst = (fill_word[1:0]==2'b11) ? fill_word : {16'b0, fill_word[15:0]}, fetch_valid = 1; go to IDLE.
- Flush (rob_clear_up high with rdy_in high):
  - From IDLE, CHECK or FILL: go to IDLE. Suppress any fetch_valid or ic_wr in that cycle; no counter update.
  - From MEM without mem_done: go to DRAIN. mem_req stays high until mem_done, because the memory port cannot be aborted.
  - From MEM with mem_done in the same cycle: discard the data, go to IDLE.
- DRAIN:
  - Wait for mem_done, discard the data, go to IDLE.
  - fetch_req is ignored here; a flush arriving during DRAIN has no further effect.
- rdy_in low: no transitions, ic_wr forced to 0, counters frozen, mem_req and address held.
- Counters saturate at 32'hFFFF_FFFF.
- Reset (asynchronous, any state, including mid-read):
  - State goes to IDLE.
  - All outputs go to 0: fetch_valid, fetch_inst, fetch_is_i, fetch_pc_out, ic_wr, ic_wdata, ic_addr, mem_req, mem_addr, hit_cnt, miss_cnt.

## Timing
- Request first seen at clock edge N:
  - CHECK is the state during cycle N+1.
  - On a hit, fetch_valid is high during cycle N+2.
  - Hit latency is 2 cycles.
- On a miss, mem_req is high from cycle N+2.
- If mem_done is high in cycle M:
  - FILL is the state in cycle M+1; ic_wr and fetch_valid are both high in M+1.
  - IDLE is the state in M+2.
- fetch_valid is never high in two consecutive cycles.
- Back-to-back hits: next request accepted at edge N+3.
- fetch_is_i is derived combinationally from the registered fetch_inst.

## Structure
- Shared constants go in Const.v: state encodings FETCH_IDLE, FETCH_CHECK, FETCH_MEM, FETCH_FILL, FETCH_DRAIN (3 bits), and the 32-bit counter saturation value.
- Sub-module sat_counter (32-bit, inc/enable/async reset) is instantiated twice, once for hits and once for misses.
- The cache array is an external instance; this block only drives its port.

## Test plan
- Cold miss:
  - Stimulus: fetch_pc=0x1000; mem_done after 3 cycles with mem_data=0x00A00093.
  - Required: mem_addr=0x1000; FILL writes ic_wdata=0x00A00093; fetch_valid with fetch_inst=0x00A00093, fetch_is_i=1; miss_cnt=1.
- Hit:
  - Stimulus: refetch 0x1000 with ic_hit=1.
  - Required: fetch_valid exactly 2 cycles after the request; hit_cnt=1; mem_req stays 0.
- Compressed miss:
  - Stimulus: fetch_pc=0x2002, mem_data=0x12344505.
  - Required: fetch_inst=0x00004505, fetch_is_i=0.
- Flush during MEM:
  - Stimulus: assert rob_clear_up 1 cycle after mem_req rises; mem_done arrives 4 cycles later.
  - Required: mem_req held until mem_done; no ic_wr and no fetch_valid; IDLE in the cycle after mem_done.
- rdy_in low for 3 cycles inside FILL.
  - Required: ic_wr=0 and fetch_valid=0 while low; a single fill and a single fetch_valid once rdy_in returns high.
- Async reset mid-MEM (rst_n_in low between clock edges).
  - Required: mem_req, fetch_valid and both counters are 0 immediately; the next request starts a fresh CHECK.
